mod_segment_serializer: RTL and testbench
=========================================

# mod_segment_serializer

Downstream of the per-segment modulation stages (`if__V_1` … `if__V_8`). Captures the registered 32-bit segment words of one modulated symbol in a single cycle and buffers up to two symbols. Replays each symbol as a stream of one segment per cycle on a valid/ready interface toward the DAC/output sample path. Counts emitted symbols and flags any symbol lost to back-pressure.

## Interface
Parameters:
- `NUM_SEG`, 8: segments per symbol; power of two, 2..16.
- `DATA_W`, 32: width of one segment word.
- `DEPTH`, 2: symbol buffer depth in entries; power of two.

Ports (clock and reset first):
- `clk` input 1: single clock; all logic rising-edge.
- `reset` input 1: synchronous, active-low; 0 at a rising edge resets the block.
- `seg_valid` input 1: one-cycle strobe; all segment words hold one complete symbol.
- `seg_data` input NUM_SEG*DATA_W: concatenated segments; segment k is at bits [k*DATA_W +: DATA_W].
- `sample_ready` input 1: downstream accepts `sample_out` this cycle.
- `sample_valid` output 1: `sample_out` holds a valid segment.
- `sample_out` output DATA_W: current segment word.
- `sample_last` output 1: `sample_out` is segment NUM_SEG-1 of its symbol.
- `symbol_count` output 16: number of fully emitted symbols; wraps modulo 2^16.
- `overflow` output 1: sticky flag; a symbol was dropped because the buffer was full.

## Operation
- Buffer: `DEPTH`-entry circular store of whole symbols.
  - Write pointer `wr_ptr`, read pointer `rd_ptr`, occupancy `count` with range 0..DEPTH.
- Load: on `seg_valid` with a free entry, write `seg_data` to the entry at `wr_ptr`, advance `wr_ptr`, and increment `count`.
- Segment index `seg_idx`, range 0..NUM_SEG-1, selects the word output from the entry at `rd_ptr`.
- Output signals:
  - `sample_valid` = (count != 0).
  - `sample_last` = sample_valid && (seg_idx == NUM_SEG-1).
- Transfer: occurs when sample_valid && sample_ready.
  - On a transfer that is not last: `seg_idx` increments.
  - On a transfer that is last: `seg_idx` returns to 0, `rd_ptr` advances, `count` decrements, and `symbol_count` increments.
- FSM:
  - EMPTY (count == 0): go to STREAM on a load.
  - STREAM: stay while count > 0; return to EMPTY when the last transfer is made with no load and count == 1.
  - FULL is count == DEPTH within STREAM.
- Boundary behaviour:
  - Load and last transfer in the same cycle while full: the load is accepted because the pop frees the slot in the same cycle. `count` is unchanged.
  - Load while full with no simultaneous last transfer: the symbol is dropped and `overflow` is set to 1. It stays 1 until reset.
  - Load and last transfer in the same cycle with count == 1: the next symbol streams with no gap.
  - sample_ready held low: `sample_out`, `sample_last` and `seg_idx` stay stable. Once sample_valid is asserted it is never deasserted before the transfer completes.
  - `symbol_count` wraps from 16'hFFFF to 0.
- Reset (reset == 0, synchronous):
  - Pointers, `count`, `seg_idx`, `symbol_count` and `overflow` go to 0; the FSM goes to EMPTY.
  - Outputs go to: `sample_valid` 0, `sample_last` 0, `sample_out` 0 (gated while invalid).
  - A reset in mid-symbol discards all buffered data; no partial symbol is emitted afterwards.

## Timing
- Latency: `seg_valid` at edge N with an empty buffer gives `sample_valid` = 1 with segment 0 after edge N.
- Throughput: one segment per cycle under continuous ready, so NUM_SEG cycles per symbol.
- An upstream symbol rate of ≤ 1 per NUM_SEG cycles never overflows when sample_ready is held at 1.
- `sample_out` comes from registered buffer contents through a NUM_SEG:1 mux; there is no combinational path from `seg_data` to any output.
- `sample_ready` affects only state updated at the next edge.

## Structure
- Shared package `modulation_pkg` holds:
  - `SEG_W` = 32 and `NUM_SEGMENTS` = 8, also used by the segment stages.
  - The FSM state enum {ST_EMPTY, ST_STREAM}.
- Sub-module `mod_symbol_fifo`: the DEPTH×(NUM_SEG*DATA_W) store with pointers, count and full/empty.
- The top level holds `seg_idx`, the output mux, counters and the overflow flag.

## Test plan
- Single symbol: after reset, pulse `seg_valid` with segment k = 32'h100+k and `sample_ready` = 1. Required: outputs 0x100..0x107 on 8 consecutive cycles, `sample_last` only on 0x107, then `symbol_count` = 1 and `sample_valid` = 0.
- Back-pressure: drop `sample_ready` for 5 cycles after the third transfer. Required: `sample_out` holds 0x103 for all 5 cycles and streaming then resumes at 0x103 with no loss.
- Overflow: hold `sample_ready` = 0 and pulse `seg_valid` 3 times. Required: `overflow` = 1 after the third pulse; releasing ready emits exactly 2 symbols, and `symbol_count` = 2.
- Simultaneous load and pop when full: with the buffer full, apply `seg_valid` in the same cycle as the last transfer. Required: no overflow, and the new symbol is emitted third, intact.
- Mid-symbol reset: assert reset low for 1 cycle during segment 4. Required: outputs 0 and `sample_valid` = 0 the next cycle; `overflow` and `symbol_count` are 0, and the next symbol starts at its segment 0.
- Counter wrap: force 65,536 symbols, or preload in simulation. Required: `symbol_count` goes from 16'hFFFF to 0.

Source files
------------

// File: rtl/modulation_pkg.sv
// Shared definitions for the modulation segment stages and the segment serializer.
package modulation_pkg;

    localparam int unsigned SEG_W        = 32;
    localparam int unsigned NUM_SEGMENTS = 8;

    typedef enum logic {
        ST_EMPTY,
        ST_STREAM
    } ser_state_e;

    // Width of an index into n items; never below 1 so single-entry stores still get a bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mod_symbol_fifo.sv
// Circular store of whole symbols. A push is accepted when a slot is free or when a pop
// in the same cycle frees one.
module mod_symbol_fifo
    import modulation_pkg::*;
#(
    parameter int unsigned WIDTH = NUM_SEGMENTS * SEG_W,
    parameter int unsigned DEPTH = 2,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             accept,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = idx_width(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pop_ok;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign pop_ok  = pop && !empty;
    assign accept  = push && (!full || pop_ok);
    assign rd_data = mem_q[rd_ptr_q];

    // Pointer and occupancy next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (accept) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        if (accept && !pop_ok) begin
            count_d = count_q + 1'b1;
        end else if (pop_ok && !accept) begin
            count_d = count_q - 1'b1;
        end
    end

    // Pointer and occupancy registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Symbol storage; contents are don't-care until count says otherwise, so no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/mod_segment_serializer.sv
// Captures a full symbol of segment words in one cycle and replays it one segment per
// cycle on a valid/ready stream, counting emitted symbols and flagging dropped ones.
module mod_segment_serializer
    import modulation_pkg::*;
#(
    parameter int unsigned NUM_SEG = NUM_SEGMENTS,
    parameter int unsigned DATA_W  = SEG_W,
    parameter int unsigned DEPTH   = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      seg_valid,
    input  logic [NUM_SEG*DATA_W-1:0] seg_data,
    input  logic                      sample_ready,
    output logic                      sample_valid,
    output logic [DATA_W-1:0]         sample_out,
    output logic                      sample_last,
    output logic [15:0]               symbol_count,
    output logic                      overflow
);

    localparam int unsigned SEG_IDX_W = idx_width(NUM_SEG);
    localparam int unsigned CNT_W     = $clog2(DEPTH + 1);

    logic [NUM_SEG*DATA_W-1:0] fifo_rd_data;
    logic [CNT_W-1:0]          fifo_count;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic                      load_ok;
    logic                      xfer;
    logic                      last_xfer;

    ser_state_e           state_q, state_d;
    logic [SEG_IDX_W-1:0] seg_idx_q, seg_idx_d;
    logic [15:0]          sym_cnt_q, sym_cnt_d;
    logic                 overflow_q, overflow_d;

    mod_symbol_fifo #(
        .WIDTH (NUM_SEG * DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (seg_valid),
        .pop     (last_xfer),
        .wr_data (seg_data),
        .rd_data (fifo_rd_data),
        .accept  (load_ok),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign sample_valid = !fifo_empty;
    assign sample_last  = sample_valid && (seg_idx_q == SEG_IDX_W'(NUM_SEG - 1));
    assign xfer         = sample_valid && sample_ready;
    assign last_xfer    = xfer && sample_last;
    assign symbol_count = sym_cnt_q;
    assign overflow     = overflow_q;

    // Segment select from the head symbol; forced to zero while nothing is valid.
    always_comb begin
        sample_out = '0;
        if (sample_valid) begin
            for (int k = 0; k < NUM_SEG; k++) begin
                if (seg_idx_q == SEG_IDX_W'(k)) begin
                    sample_out = fifo_rd_data[k*DATA_W +: DATA_W];
                end
            end
        end
    end

    // FSM, segment index, symbol counter and sticky overflow next-state.
    always_comb begin
        state_d    = state_q;
        seg_idx_d  = seg_idx_q;
        sym_cnt_d  = sym_cnt_q;
        overflow_d = overflow_q;

        unique case (state_q)
            ST_EMPTY: begin
                if (load_ok) begin
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (last_xfer && !load_ok && (fifo_count == CNT_W'(1))) begin
                    state_d = ST_EMPTY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase

        if (last_xfer) begin
            seg_idx_d = '0;
            sym_cnt_d = sym_cnt_q + 16'd1;
        end else if (xfer) begin
            seg_idx_d = seg_idx_q + 1'b1;
        end

        // A load into a full store without a same-cycle pop is lost.
        if (seg_valid && fifo_full && !last_xfer) begin
            overflow_d = 1'b1;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_EMPTY;
            seg_idx_q  <= '0;
            sym_cnt_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            seg_idx_q  <= seg_idx_d;
            sym_cnt_q  <= sym_cnt_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: tb/tb_mod_segment_serializer.sv
// Directed bench for mod_segment_serializer: a vector table for single-symbol streaming
// and back-pressure, then hand sequences for overflow, full load/pop, reset and wrap.
module tb_mod_segment_serializer;
    import modulation_pkg::*;

    localparam int unsigned NS = 8;
    localparam int unsigned DW = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic             seg_valid;
    logic [NS*DW-1:0] seg_data;
    logic             sample_ready;
    logic             sample_valid;
    logic [DW-1:0]    sample_out;
    logic             sample_last;
    logic [15:0]      symbol_count;
    logic             overflow;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        sv;
        logic [31:0] base;
        logic        rdy;
        logic        exp_valid;
        logic [31:0] exp_out;
        logic        exp_last;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    mod_segment_serializer #(
        .NUM_SEG (NS),
        .DATA_W  (DW),
        .DEPTH   (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .seg_valid    (seg_valid),
        .seg_data     (seg_data),
        .sample_ready (sample_ready),
        .sample_valid (sample_valid),
        .sample_out   (sample_out),
        .sample_last  (sample_last),
        .symbol_count (symbol_count),
        .overflow     (overflow)
    );

    function automatic logic [NS*DW-1:0] make_sym(input logic [31:0] base);
        logic [NS*DW-1:0] r;
        for (int k = 0; k < NS; k++) r[k*DW +: DW] = base + 32'(k);
        return r;
    endfunction

    function automatic void add_vec(input logic sv, input logic [31:0] base, input logic rdy,
                                    input logic ev, input logic [31:0] eo, input logic el,
                                    input logic [15:0] ec);
        vec_t v;
        v.sv = sv; v.base = base; v.rdy = rdy;
        v.exp_valid = ev; v.exp_out = eo; v.exp_last = el; v.exp_cnt = ec;
        vecs.push_back(v);
    endfunction

    function automatic void push_sym(input logic [31:0] base);
        for (int k = 0; k < NS; k++) exp_q.push_back(base + 32'(k));
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0; seg_valid = 1'b0; sample_ready = 1'b0; seg_data = '0;
        step();
        step();
        reset = 1'b1;
    endtask

    // Streams with ready high, checking every segment against exp_q until valid drops.
    task automatic drain(input string name, input int bound);
        int n = 0;
        sample_ready = 1'b1;
        seg_valid    = 1'b0;
        for (int c = 0; c < bound; c++) begin
            if (!sample_valid) break;
            if (n < exp_q.size()) begin
                check({name, "_out"}, sample_out, exp_q[n]);
                check({name, "_last"}, 32'(sample_last), 32'((n % NS) == NS - 1));
            end
            n++;
            step();
        end
        check({name, "_nseg"}, 32'(n), 32'(exp_q.size()));
        check({name, "_idle"}, 32'(sample_valid), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Single symbol, then a second one with 5 cycles of back-pressure after 3 transfers.
        add_vec(1'b1, 32'h100, 1'b1, 1'b1, 32'h100, 1'b0, 16'd0);
        for (int k = 1; k < 8; k++) add_vec(1'b0, 0, 1'b1, 1'b1, 32'h100 + 32'(k), k == 7, 16'd0);
        add_vec(1'b0, 0, 1'b1, 1'b0, 32'h0, 1'b0, 16'd1);
        add_vec(1'b1, 32'h100, 1'b1, 1'b1, 32'h100, 1'b0, 16'd1);
        for (int k = 1; k < 4; k++) add_vec(1'b0, 0, 1'b1, 1'b1, 32'h100 + 32'(k), 1'b0, 16'd1);
        for (int k = 0; k < 5; k++) add_vec(1'b0, 0, 1'b0, 1'b1, 32'h103, 1'b0, 16'd1);
        for (int k = 4; k < 8; k++) add_vec(1'b0, 0, 1'b1, 1'b1, 32'h100 + 32'(k), k == 7, 16'd1);
        add_vec(1'b0, 0, 1'b1, 1'b0, 32'h0, 1'b0, 16'd2);

        do_reset();
        check("rst_valid", 32'(sample_valid), 32'd0);
        check("rst_out", sample_out, 32'd0);
        check("rst_last", 32'(sample_last), 32'd0);
        check("rst_count", 32'(symbol_count), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);

        foreach (vecs[i]) begin
            seg_valid    = vecs[i].sv;
            seg_data     = make_sym(vecs[i].base);
            sample_ready = vecs[i].rdy;
            step();
            check($sformatf("vec%0d_valid", i), 32'(sample_valid), 32'(vecs[i].exp_valid));
            check($sformatf("vec%0d_out", i), sample_out, vecs[i].exp_out);
            check($sformatf("vec%0d_last", i), 32'(sample_last), 32'(vecs[i].exp_last));
            check($sformatf("vec%0d_count", i), 32'(symbol_count), 32'(vecs[i].exp_cnt));
        end
        check("vec_ovf", 32'(overflow), 32'd0);

        // Overflow: three loads into a 2-deep store with ready low.
        do_reset();
        seg_valid = 1'b1; seg_data = make_sym(32'h300); step();
        seg_data = make_sym(32'h400); step();
        check("ovf_before", 32'(overflow), 32'd0);
        seg_data = make_sym(32'h500); step();
        seg_valid = 1'b0;
        check("ovf_set", 32'(overflow), 32'd1);
        push_sym(32'h300);
        push_sym(32'h400);
        drain("ovf_drain", 40);
        check("ovf_count", 32'(symbol_count), 32'd2);
        check("ovf_sticky", 32'(overflow), 32'd1);

        // Mid-symbol reset with overflow and symbol_count nonzero.
        seg_valid = 1'b1; seg_data = make_sym(32'hA00); sample_ready = 1'b1; step();
        seg_valid = 1'b0;
        for (int k = 0; k < 4; k++) step();
        check("mrst_seg4", sample_out, 32'hA04);
        reset = 1'b0; step(); reset = 1'b1;
        check("mrst_valid", 32'(sample_valid), 32'd0);
        check("mrst_out", sample_out, 32'd0);
        check("mrst_last", 32'(sample_last), 32'd0);
        check("mrst_count", 32'(symbol_count), 32'd0);
        check("mrst_ovf", 32'(overflow), 32'd0);
        step();
        check("mrst_stay_idle", 32'(sample_valid), 32'd0);
        seg_valid = 1'b1; seg_data = make_sym(32'hB00); step();
        push_sym(32'hB00);
        drain("mrst_next", 20);

        // Full store: load coincides with the last transfer of the head symbol.
        do_reset();
        seg_valid = 1'b1; seg_data = make_sym(32'h600); step();
        seg_data = make_sym(32'h700); step();
        seg_valid = 1'b0; sample_ready = 1'b1;
        for (int k = 0; k < 7; k++) step();
        check("full_head_last", sample_out, 32'h607);
        check("full_head_lastf", 32'(sample_last), 32'd1);
        seg_valid = 1'b1; seg_data = make_sym(32'h800); step();
        seg_valid = 1'b0;
        check("full_no_ovf", 32'(overflow), 32'd0);
        push_sym(32'h700);
        push_sym(32'h800);
        drain("full_drain", 40);
        check("full_count", 32'(symbol_count), 32'd3);
        check("full_ovf_end", 32'(overflow), 32'd0);

        // Wrap of symbol_count, with a back-to-back load at count == 1.
        do_reset();
        force dut.sym_cnt_q = 16'hFFFE;
        #1;
        release dut.sym_cnt_q;
        seg_valid = 1'b1; seg_data = make_sym(32'hC00); sample_ready = 1'b1; step();
        seg_valid = 1'b0;
        for (int k = 0; k < 7; k++) step();
        check("wrap_d_last", sample_out, 32'hC07);
        seg_valid = 1'b1; seg_data = make_sym(32'hD00); step();
        seg_valid = 1'b0;
        check("wrap_ffff", 32'(symbol_count), 32'h0000FFFF);
        check("nogap_valid", 32'(sample_valid), 32'd1);
        check("nogap_out", sample_out, 32'hD00);
        for (int k = 0; k < 7; k++) step();
        check("wrap_e_last", sample_out, 32'hD07);
        step();
        check("wrap_zero", 32'(symbol_count), 32'd0);
        check("wrap_idle", 32'(sample_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
